// File: rtl/universal_shift_register.sv
// Universal shift register: hold / shift right / shift left / parallel load, plus a
// counted burst of shifts controlled by a two-state FSM with registered busy/done.
//
// state | meaning
// IDLE  | mode applied each edge; start with a shift mode launches a burst
// BURST | one shift per edge in the latched direction until the count runs out
module universal_shift_register #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 4
) (
  input  logic               clk,
  input  logic               clear,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   par_in,
  input  logic               sin_r,
  input  logic               sin_l,
  input  logic               start,
  input  logic [COUNT_W-1:0] shift_cnt,
  output logic [WIDTH-1:0]   q,
  output logic               sout_r,
  output logic               sout_l,
  output logic               busy,
  output logic               done
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               dir_left_q, dir_left_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   shr_val, shl_val;

  assign shr_val = {sin_r, data_q[WIDTH-1:1]};
  assign shl_val = {data_q[WIDTH-2:0], sin_l};

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q    <= IDLE;
      data_q     <= '0;
      cnt_q      <= '0;
      dir_left_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      dir_left_q <= dir_left_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    dir_left_d = dir_left_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // start only means something with a shift mode; otherwise it is plain operation
        if (start && (mode == MODE_RIGHT || mode == MODE_LEFT)) begin
          dir_left_d = (mode == MODE_LEFT);
          if (shift_cnt == '0) begin
            done_d = 1'b1;
          end else begin
            cnt_d   = shift_cnt;
            state_d = BURST;
            busy_d  = 1'b1;
          end
        end else begin
          unique case (mode)
            MODE_HOLD:  data_d = data_q;
            MODE_RIGHT: data_d = shr_val;
            MODE_LEFT:  data_d = shl_val;
            MODE_LOAD:  data_d = par_in;
            default:    data_d = data_q;
          endcase
        end
      end
      BURST: begin
        data_d = dir_left_q ? shl_val : shr_val;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == {{(COUNT_W-1){1'b0}}, 1'b1}) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign q      = data_q;
  assign sout_r = data_q[0];
  assign sout_l = data_q[WIDTH-1];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register (WIDTH=8, COUNT_W=4): hand-computed
// vectors for each operation, bursts, zero/maximum counts and asynchronous clear.
module tb_universal_shift_register;

  logic       clk = 1'b0;
  logic       clear;
  logic [1:0] mode;
  logic [7:0] par_in;
  logic       sin_r, sin_l, start;
  logic [3:0] shift_cnt;
  logic [7:0] q;
  logic       sout_r, sout_l, busy, done;

  int errors = 0;
  int checks = 0;
  int busy_cycles;

  universal_shift_register #(.WIDTH(8), .COUNT_W(4)) dut (
    .clk(clk), .clear(clear), .mode(mode), .par_in(par_in), .sin_r(sin_r),
    .sin_l(sin_l), .start(start), .shift_cnt(shift_cnt), .q(q),
    .sout_r(sout_r), .sout_l(sout_l), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
    check({tag, "_q"}, {24'd0, q}, {24'd0, eq});
    check({tag, "_busy"}, {31'd0, busy}, {31'd0, eb});
    check({tag, "_done"}, {31'd0, done}, {31'd0, ed});
  endtask

  initial begin
    clear = 1'b1; mode = 2'b00; par_in = 8'h00; sin_r = 1'b0; sin_l = 1'b0;
    start = 1'b0; shift_cnt = 4'd0;
    #3;
    check_state("por", 8'h00, 1'b0, 1'b0);
    clear = 1'b0;

    // load then asynchronous clear between edges
    mode = 2'b11; par_in = 8'hA5;
    tick();
    check("load_a5", {24'd0, q}, 32'hA5);
    #2 clear = 1'b1;
    #1 check_state("async_clr", 8'h00, 1'b0, 1'b0);
    clear = 1'b0;

    // basic ops
    tick();
    check("reload_a5", {24'd0, q}, 32'hA5);
    mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold", {24'd0, q}, 32'hA5);
    end
    mode = 2'b01; sin_r = 1'b1;
    tick();
    check("shr_d2", {24'd0, q}, 32'hD2);
    check("shr_sout_r", {31'd0, sout_r}, 32'd0);
    check("shr_sout_l", {31'd0, sout_l}, 32'd1);

    // left shift
    mode = 2'b11; par_in = 8'hA5;
    tick();
    mode = 2'b10; sin_l = 1'b0;
    tick();
    check("shl_4a", {24'd0, q}, 32'h4A);
    check("shl_sout_l0", {31'd0, sout_l}, 32'd0);
    check("shl_sout_r0", {31'd0, sout_r}, 32'd0);
    sin_l = 1'b1;
    tick();
    check("shl_95", {24'd0, q}, 32'h95);
    check("shl_sout_l1", {31'd0, sout_l}, 32'd1);
    check("shl_sout_r1", {31'd0, sout_r}, 32'd1);

    // 3-shift left burst, mode=11 during the burst must be ignored
    mode = 2'b11; par_in = 8'h81;
    tick();
    start = 1'b1; mode = 2'b10; shift_cnt = 4'd3; sin_l = 1'b1;
    tick();
    check_state("b3_t0", 8'h81, 1'b1, 1'b0);
    start = 1'b0; mode = 2'b11; par_in = 8'hFF; shift_cnt = 4'd9;
    tick();
    check_state("b3_t1", 8'h03, 1'b1, 1'b0);
    tick();
    check_state("b3_t2", 8'h07, 1'b1, 1'b0);
    tick();
    check_state("b3_t3", 8'h0F, 1'b0, 1'b1);
    mode = 2'b00;
    tick();
    check_state("b3_after", 8'h0F, 1'b0, 1'b0);

    // zero-count burst: done only
    start = 1'b1; mode = 2'b01; shift_cnt = 4'd0; sin_r = 1'b1;
    tick();
    check_state("b0_t0", 8'h0F, 1'b0, 1'b1);
    start = 1'b0; mode = 2'b00;
    tick();
    check_state("b0_t1", 8'h0F, 1'b0, 1'b0);

    // maximum burst of 15 right shifts with sin_r=0
    start = 1'b1; mode = 2'b01; shift_cnt = 4'd15; sin_r = 1'b0;
    tick();
    start = 1'b0; mode = 2'b00;
    busy_cycles = 0;
    if (busy) busy_cycles++;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (busy) busy_cycles++;
    end
    check("b15_busy_cycles", busy_cycles, 32'd15);
    check_state("b15_end", 8'h00, 1'b0, 1'b1);

    // new request accepted in the done cycle
    start = 1'b1; mode = 2'b10; shift_cnt = 4'd1; sin_l = 1'b1;
    tick();
    check_state("b1_t0", 8'h00, 1'b1, 1'b0);
    start = 1'b0; mode = 2'b00;
    tick();
    check_state("b1_t1", 8'h01, 1'b0, 1'b1);

    // clear during the second shift of a 5-shift burst
    mode = 2'b11; par_in = 8'h3C;
    tick();
    start = 1'b1; mode = 2'b01; shift_cnt = 4'd5; sin_r = 1'b0;
    tick();
    check_state("b5_t0", 8'h3C, 1'b1, 1'b0);
    start = 1'b0; mode = 2'b00;
    tick();
    check_state("b5_t1", 8'h1E, 1'b1, 1'b0);
    #2 clear = 1'b1;
    #1 check_state("b5_clr", 8'h00, 1'b0, 1'b0);
    clear = 1'b0;
    tick();
    check_state("b5_post", 8'h00, 1'b0, 1'b0);
    tick();
    check_state("b5_post2", 8'h00, 1'b0, 1'b0);

    // recovery burst of 2 left shifts
    start = 1'b1; mode = 2'b10; shift_cnt = 4'd2; sin_l = 1'b1;
    tick();
    check_state("b2_t0", 8'h00, 1'b1, 1'b0);
    start = 1'b0; mode = 2'b00;
    tick();
    check_state("b2_t1", 8'h01, 1'b1, 1'b0);
    tick();
    check_state("b2_t2", 8'h03, 1'b0, 1'b1);
    tick();
    check_state("b2_t3", 8'h03, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
